// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input registered multiplexer with valid/ready handshakes.
// MODE 0 selects the channel given by sel; MODE 1 arbitrates round-robin
// among valid channels. One output register stage with full back-pressure.
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] chan [N];
  logic [SELW-1:0]  ptr;

  logic             load;
  logic             fx_ok;
  logic             hi_found, lo_found;
  logic [SELW-1:0]  hi_idx, lo_idx;
  logic             gnt_ok;
  logic [SELW-1:0]  gnt;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  ptr_next;

  // Unpack the flat data bus and drive the one-hot acceptance per channel.
  for (genvar gi = 0; gi < N; gi++) begin : gen_chan
    assign chan[gi]     = in_data[gi*WIDTH +: WIDTH];
    assign in_ready[gi] = load && gnt_ok && (gnt == SELW'(gi));
  end

  // The output register can take new data when empty or being drained.
  assign load = !out_valid || out_ready;

  // Fixed select: an out-of-range sel matches no channel and never grants.
  always_comb begin
    fx_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) fx_ok = in_valid[i];
    end
  end

  // Round-robin scan: lowest valid index at or above ptr, else lowest below.
  // Walking downwards lets the last hit (the lowest index) win each class.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (SELW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = SELW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SELW'(i);
        end
      end
    end
  end

  // Grant selection by mode, and the data of the granted channel.
  always_comb begin
    if (MODE == 1) begin
      gnt_ok = hi_found || lo_found;
      gnt    = hi_found ? hi_idx : lo_idx;
    end else begin
      gnt_ok = fx_ok;
      gnt    = sel;
    end
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) gnt_data = chan[i];
    end
  end

  // Explicit wrap keeps ptr inside 0..N-1 for any N.
  assign ptr_next = (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;

  // Output register and arbitration pointer; both hold under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (gnt_ok) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_src   <= gnt;
        if (MODE == 1) ptr <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Testbench for arb_mux_n: three instances (fixed N=4, round-robin N=3,
// round-robin N=4) with a queue-based scoreboard and a reference model.
module tb_arb_mux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0]   iv    [3];
  logic [127:0] idata [3];
  logic [2:0]   isel  [3];
  logic         ordy  [3];

  typedef struct {
    logic [31:0] d;
    int          s;
  } item_t;

  // Expected grant from the plain rules: -1 means no grant.
  function automatic int ref_grant(int n, int mode, int s, logic [3:0] v, int p);
    int c;
    if (mode == 0) begin
      if (s < n) begin
        if (v[s]) return s;
      end
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    localparam int NN = (gi == 1) ? 3 : 4;
    localparam int MM = (gi == 0) ? 0 : 1;
    localparam int SW = (gi == 0) ? 3 : 2;

    logic [NN-1:0] ir;
    logic          ov;
    logic [31:0]   od;
    logic [SW-1:0] os;

    item_t q[$];
    int    m_full = 0;
    int    m_ptr  = 0;
    int    g_m;
    logic  ld_m;
    item_t it_m;
    item_t ex_m;

    arb_mux_n #(.WIDTH(32), .N(NN), .SELW(SW), .MODE(MM)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[gi][NN-1:0]),
      .in_data   (idata[gi][NN*32-1:0]),
      .in_ready  (ir),
      .sel       (isel[gi][SW-1:0]),
      .out_valid (ov),
      .out_data  (od),
      .out_src   (os),
      .out_ready (ordy[gi])
    );

    // Reference model: predicts handshake, state and pushes expected outputs.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        m_full = 0;
        m_ptr  = 0;
      end else begin
        ld_m = (m_full == 0) || ordy[gi];
        g_m  = ref_grant(NN, MM, int'(isel[gi][SW-1:0]), iv[gi], m_ptr);
        chk($sformatf("dut%0d in_ready", gi), 64'(ir),
            (ld_m && g_m >= 0) ? (64'd1 << g_m) : 64'd0);
        chk($sformatf("dut%0d out_valid", gi), 64'(ov), 64'(m_full));
        chk($sformatf("dut%0d ptr", gi), 64'(u_dut.ptr), 64'(m_ptr));
        if (ld_m) begin
          if (g_m >= 0) begin
            it_m.d = idata[gi][g_m*32 +: 32];
            it_m.s = g_m;
            q.push_back(it_m);
            m_full = 1;
            if (MM == 1) m_ptr = (g_m + 1) % NN;
          end else begin
            m_full = 0;
          end
        end
      end
    end

    // Monitor: compares what the DUT presents against the queue head.
    always @(negedge clk) begin
      if (!rst && ov === 1'b1) begin
        chk($sformatf("dut%0d queue nonempty", gi), 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          ex_m = q[0];
          chk($sformatf("dut%0d out_data", gi), 64'(od), 64'(ex_m.d));
          chk($sformatf("dut%0d out_src", gi), 64'(os), 64'(ex_m.s));
          if (ordy[gi]) q.delete(0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]    = '0;
      idata[i] = '0;
      isel[i]  = '0;
      ordy[i]  = 1'b1;
    end
    rst = 1'b1;
    repeat (2) cyc();
    chk("reset dut0 out_valid", 64'(gen_dut[0].ov), 64'd0);
    chk("reset dut0 out_data", 64'(gen_dut[0].od), 64'd0);
    chk("reset dut0 out_src", 64'(gen_dut[0].os), 64'd0);
    chk("reset dut2 ptr", 64'(gen_dut[2].u_dut.ptr), 64'd0);
    rst = 1'b0;
    cyc();

    // Fixed select of channel 2, three consecutive loads.
    idata[0] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    iv[0]    = 4'hF;
    isel[0]  = 3'd2;
    #1;
    chk("fixed in_ready before edge", 64'(gen_dut[0].ir), 64'b0100);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fixed out_data", 64'(gen_dut[0].od), 64'h33333333);
      chk("fixed out_src", 64'(gen_dut[0].os), 64'd2);
      chk("fixed in_ready", 64'(gen_dut[0].ir), 64'b0100);
    end

    // Back-pressure: everything holds while out_ready is low.
    isel[0] = 3'd1;
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp out_data", 64'(gen_dut[0].od), 64'h33333333);
      chk("bp out_valid", 64'(gen_dut[0].ov), 64'd1);
      chk("bp in_ready", 64'(gen_dut[0].ir), 64'd0);
    end
    ordy[0] = 1'b1;
    cyc();
    chk("bp release out_data", 64'(gen_dut[0].od), 64'h22222222);
    chk("bp release out_valid", 64'(gen_dut[0].ov), 64'd1);

    // Out-of-range select: no grant, output empties, data holds.
    isel[0] = 3'd4;
    cyc();
    chk("badsel out_valid", 64'(gen_dut[0].ov), 64'd0);
    chk("badsel in_ready", 64'(gen_dut[0].ir), 64'd0);
    chk("badsel out_data hold", 64'(gen_dut[0].od), 64'h22222222);
    iv[0] = '0;

    // Round-robin wrap with N=3.
    idata[1] = {32'h0, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    iv[1]    = 4'b0111;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rr3 out_src", 64'(gen_dut[1].os), 64'(k % 3));
      chk("rr3 ptr range", 64'(gen_dut[1].u_dut.ptr < 2'd3), 64'd1);
    end
    iv[1] = '0;

    // Round-robin skip with channels 1 and 3, then 1 alone.
    idata[2] = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    iv[2]    = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr4 skip out_src", 64'(gen_dut[2].os), (k % 2 == 0) ? 64'd1 : 64'd3);
    end
    iv[2] = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rr4 single out_src", 64'(gen_dut[2].os), 64'd1);
      chk("rr4 single ptr", 64'(gen_dut[2].u_dut.ptr), 64'd2);
    end

    // Drain with no valid inputs once the consumer accepts.
    iv[2]   = '0;
    ordy[2] = 1'b0;
    repeat (2) cyc();
    chk("drain hold out_valid", 64'(gen_dut[2].ov), 64'd1);
    ordy[2] = 1'b1;
    cyc();
    chk("drain out_valid", 64'(gen_dut[2].ov), 64'd0);

    // Randomized traffic on all instances.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]    = 4'($urandom);
        idata[i] = {$urandom, $urandom, $urandom, $urandom};
        isel[i]  = 3'($urandom_range(0, 7));
        ordy[i]  = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    // Asynchronous reset while FULL with out_src=2 and ptr=3.
    iv[2]   = 4'b0100;
    ordy[2] = 1'b1;
    cyc();
    iv[2]   = '0;
    ordy[2] = 1'b0;
    chk("pre-rst out_src", 64'(gen_dut[2].os), 64'd2);
    chk("pre-rst ptr", 64'(gen_dut[2].u_dut.ptr), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(gen_dut[2].ov), 64'd0);
    chk("async rst out_data", 64'(gen_dut[2].od), 64'd0);
    chk("async rst out_src", 64'(gen_dut[2].os), 64'd0);
    chk("async rst ptr", 64'(gen_dut[2].u_dut.ptr), 64'd0);
    @(negedge clk);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = '0;
      ordy[i] = 1'b1;
    end
    iv[2] = 4'hF;
    cyc();
    chk("post-rst first grant", 64'(gen_dut[2].os), 64'd0);
    chk("post-rst out_valid", 64'(gen_dut[2].ov), 64'd1);

    // Let everything drain, then confirm the scoreboards are empty.
    iv[2] = '0;
    repeat (3) cyc();
    chk("dut0 scoreboard drained", 64'(gen_dut[0].q.size()), 64'd0);
    chk("dut1 scoreboard drained", 64'(gen_dut[1].q.size()), 64'd0);
    chk("dut2 scoreboard drained", 64'(gen_dut[2].q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
